alu_ctl_ex: RTL and testbench
=============================

// Module: alu_ctl_ex
// PURPOSE
//  Producer side of the EX-stage ALU interface. Decodes opcode/funct in ID into the 4-bit ALU control
//  code, forms operands a/b (incl. immediate extension) and registers all into the ID/EX pipeline
//  register with stall/flush control. The ALU consumes ex_ctl/ex_a/ex_b directly in the next cycle.
// PARAMETERS
//  WIDTH    32       datapath width (a, b, rs/rt data); immediate extension targets WIDTH
//  NOP_CTL  4'b0000  ctl value driven for bubbles and reserved instructions (AND)
// PORTS
//  clk         in   1      clock, all state on rising edge
//  reset_n     in   1      asynchronous active-low reset
//  id_valid    in   1      instruction in ID is real (0 = bubble)
//  id_op       in   6      opcode [31:26]
//  id_funct    in   6      funct [5:0]
//  id_imm      in   16     immediate [15:0]
//  id_rs_data  in   WIDTH  register rs value (already forwarded)
//  id_rt_data  in   WIDTH  register rt value (already forwarded)
//  stall       in   1      hold ID/EX contents
//  flush       in   1      replace ID/EX contents with bubble
//  ex_valid    out  1      EX holds a real instruction
//  ex_ctl      out  4      ALU control: 0010 add,0110 sub,0000 and,0001 or,1100 nor,1101 xor,0111 slt
//  ex_a        out  WIDTH  ALU operand a
//  ex_b        out  WIDTH  ALU operand b
//  ex_ovf_en   out  1      signed-overflow trap enabled (add, sub, addi only)
//  ex_branch   out  2      00 none, 01 beq, 10 bne (consumer tests ALU z)
//  ex_ri       out  1      reserved-instruction exception flag
// BEHAVIOUR
//  Reset (async, reset_n=0): ex_valid=0, ex_ctl=NOP_CTL, ex_a=ex_b=0, ex_ovf_en=0, ex_branch=00,
//   ex_ri=0. Release is sampled on next rising edge; no output changes until then.
//  Latency: 1 cycle. ID inputs on edge N appear on ex_* after edge N; decode is combinational in ID.
//  Register update priority per edge: flush > stall > load.
//   flush=1: load bubble (reset values), regardless of stall.
//   stall=1, flush=0: all ex_* hold previous values.
//   else: load decoded ID values; id_valid=0 loads bubble.
//  Decode, op=000000 (R-type), a=rs, b=rt, ovf_en per funct:
//   20 add->0010 ovf; 21 addu->0010; 22 sub->0110 ovf; 23 subu->0110; 24 and->0000;
//   25 or->0001; 26 xor->1101; 27 nor->1100; 2A slt->0111; other funct->ex_ri=1.
//  Decode, I-type, a=rs, b=ext(imm):
//   08 addi->0010 sext ovf; 09 addiu->0010 sext; 0A slti->0111 sext;
//   0C andi->0000 zext; 0D ori->0001 zext; 0E xori->1101 zext;
//   23 lw / 2B sw->0010 sext (address calc, no ovf);
//   04 beq / 05 bne->0110, b=rt, ex_branch=01/10;
//   0F lui->0001, a=0, b={imm,16'b0} (upper WIDTH-16 bits hold imm, low 16 zero).
//   Any other opcode->ex_ri=1.
//  sext = {{(WIDTH-16){imm[15]}},imm}; zext = {{(WIDTH-16){1'b0}},imm}.
//  Reserved instruction: ex_valid=1, ex_ri=1, ex_ctl=NOP_CTL, ex_a=ex_b=0, ovf_en=0, branch=00.
//  ex_ri, ex_ovf_en, ex_branch always 0 when ex_valid=0.
//  Reset mid-stall/flush: reset dominates immediately; stall/flush ignored while reset_n=0.
// TESTING
//  1. reset_n=0 mid-stream with ex_valid=1 -> all ex_* at reset values before next edge; hold while low.
//  2. R-type add, rs=7FFFFFFF, rt=1 -> next cycle ex_ctl=0010, a=7FFFFFFF, b=1, ovf_en=1; addu same with ovf_en=0.
//  3. andi imm=8000, ori imm=FFFF vs addi imm=8000 -> b=00008000, 0000FFFF, FFFF8000 respectively.
//  4. lui imm=1234, rs=FFFFFFFF -> ctl=0001, a=0, b=12340000; beq -> ctl=0110, ex_branch=01.
//  5. stall=1 for 3 cycles while ID changes -> ex_* frozen; stall+flush same edge -> bubble (ex_valid=0).
//  6. op=3F and op=0/funct=3F -> ex_valid=1, ex_ri=1, ex_ctl=0000, a=b=0; id_valid=0 -> bubble, ex_ri=0.

Source files
------------

// File: rtl/alu_ctl_ex.sv
// ID-side ALU control decode and ID/EX pipeline register.
// Produces ctl/operands consumed by the EX-stage ALU one cycle later.
module alu_ctl_ex #(
    parameter int         WIDTH   = 32,
    parameter logic [3:0] NOP_CTL = 4'b0000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             id_valid,
    input  logic [5:0]       id_op,
    input  logic [5:0]       id_funct,
    input  logic [15:0]      id_imm,
    input  logic [WIDTH-1:0] id_rs_data,
    input  logic [WIDTH-1:0] id_rt_data,
    input  logic             stall,
    input  logic             flush,
    output logic             ex_valid,
    output logic [3:0]       ex_ctl,
    output logic [WIDTH-1:0] ex_a,
    output logic [WIDTH-1:0] ex_b,
    output logic             ex_ovf_en,
    output logic [1:0]       ex_branch,
    output logic             ex_ri
);

    localparam logic [3:0] CTL_ADD = 4'b0010;
    localparam logic [3:0] CTL_SUB = 4'b0110;
    localparam logic [3:0] CTL_AND = 4'b0000;
    localparam logic [3:0] CTL_OR  = 4'b0001;
    localparam logic [3:0] CTL_NOR = 4'b1100;
    localparam logic [3:0] CTL_XOR = 4'b1101;
    localparam logic [3:0] CTL_SLT = 4'b0111;

    logic             valid_d, valid_q;
    logic [3:0]       ctl_d, ctl_q;
    logic [WIDTH-1:0] a_d, a_q;
    logic [WIDTH-1:0] b_d, b_q;
    logic             ovf_d, ovf_q;
    logic [1:0]       br_d, br_q;
    logic             ri_d, ri_q;
    logic [WIDTH-1:0] sext, zext;

    assign sext = {{(WIDTH-16){id_imm[15]}}, id_imm};
    assign zext = {{(WIDTH-16){1'b0}}, id_imm};

    always_comb begin
        valid_d = id_valid;
        ctl_d   = NOP_CTL;
        a_d     = '0;
        b_d     = '0;
        ovf_d   = 1'b0;
        br_d    = 2'b00;
        ri_d    = 1'b0;
        case (id_op)
            6'h00: begin
                a_d = id_rs_data;
                b_d = id_rt_data;
                case (id_funct)
                    6'h20: begin ctl_d = CTL_ADD; ovf_d = 1'b1; end
                    6'h21: ctl_d = CTL_ADD;
                    6'h22: begin ctl_d = CTL_SUB; ovf_d = 1'b1; end
                    6'h23: ctl_d = CTL_SUB;
                    6'h24: ctl_d = CTL_AND;
                    6'h25: ctl_d = CTL_OR;
                    6'h26: ctl_d = CTL_XOR;
                    6'h27: ctl_d = CTL_NOR;
                    6'h2A: ctl_d = CTL_SLT;
                    default: ri_d = 1'b1;
                endcase
            end
            6'h08: begin
                ctl_d = CTL_ADD; a_d = id_rs_data; b_d = sext; ovf_d = 1'b1;
            end
            6'h09, 6'h23, 6'h2B: begin
                ctl_d = CTL_ADD; a_d = id_rs_data; b_d = sext;
            end
            6'h0A: begin ctl_d = CTL_SLT; a_d = id_rs_data; b_d = sext; end
            6'h0C: begin ctl_d = CTL_AND; a_d = id_rs_data; b_d = zext; end
            6'h0D: begin ctl_d = CTL_OR;  a_d = id_rs_data; b_d = zext; end
            6'h0E: begin ctl_d = CTL_XOR; a_d = id_rs_data; b_d = zext; end
            6'h04, 6'h05: begin
                ctl_d = CTL_SUB;
                a_d   = id_rs_data;
                b_d   = id_rt_data;
                br_d  = id_op[0] ? 2'b10 : 2'b01;
            end
            // lui: OR with a zero operand places imm in the upper half
            6'h0F: begin ctl_d = CTL_OR; b_d = zext << 16; end
            default: ri_d = 1'b1;
        endcase
        if (ri_d || !id_valid) begin
            ctl_d = NOP_CTL;
            a_d   = '0;
            b_d   = '0;
            ovf_d = 1'b0;
            br_d  = 2'b00;
        end
        if (!id_valid) ri_d = 1'b0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= 1'b0;
            ctl_q   <= NOP_CTL;
            a_q     <= '0;
            b_q     <= '0;
            ovf_q   <= 1'b0;
            br_q    <= 2'b00;
            ri_q    <= 1'b0;
        end else if (flush) begin
            valid_q <= 1'b0;
            ctl_q   <= NOP_CTL;
            a_q     <= '0;
            b_q     <= '0;
            ovf_q   <= 1'b0;
            br_q    <= 2'b00;
            ri_q    <= 1'b0;
        end else if (!stall) begin
            valid_q <= valid_d;
            ctl_q   <= ctl_d;
            a_q     <= a_d;
            b_q     <= b_d;
            ovf_q   <= ovf_d;
            br_q    <= br_d;
            ri_q    <= ri_d;
        end
    end

    assign ex_valid  = valid_q;
    assign ex_ctl    = ctl_q;
    assign ex_a      = a_q;
    assign ex_b      = b_q;
    assign ex_ovf_en = ovf_q;
    assign ex_branch = br_q;
    assign ex_ri     = ri_q;

endmodule

// File: tb/tb_alu_ctl_ex.sv
// Directed bench for alu_ctl_ex with hand-computed expectations.
// Inputs change on falling edges; outputs are sampled on falling edges.
module tb_alu_ctl_ex;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        id_valid;
    logic [5:0]  id_op;
    logic [5:0]  id_funct;
    logic [15:0] id_imm;
    logic [31:0] id_rs_data;
    logic [31:0] id_rt_data;
    logic        stall;
    logic        flush;
    logic        ex_valid;
    logic [3:0]  ex_ctl;
    logic [31:0] ex_a;
    logic [31:0] ex_b;
    logic        ex_ovf_en;
    logic [1:0]  ex_branch;
    logic        ex_ri;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    alu_ctl_ex #(.WIDTH(32), .NOP_CTL(4'b0000)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .id_valid   (id_valid),
        .id_op      (id_op),
        .id_funct   (id_funct),
        .id_imm     (id_imm),
        .id_rs_data (id_rs_data),
        .id_rt_data (id_rt_data),
        .stall      (stall),
        .flush      (flush),
        .ex_valid   (ex_valid),
        .ex_ctl     (ex_ctl),
        .ex_a       (ex_a),
        .ex_b       (ex_b),
        .ex_ovf_en  (ex_ovf_en),
        .ex_branch  (ex_branch),
        .ex_ri      (ex_ri)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic expect_all(input string tag, input logic v,
                              input logic [3:0] ctl, input logic [31:0] a,
                              input logic [31:0] b, input logic ovf,
                              input logic [1:0] br, input logic ri);
        chk({tag, ".valid"}, {31'b0, ex_valid}, {31'b0, v});
        chk({tag, ".ctl"}, {28'b0, ex_ctl}, {28'b0, ctl});
        chk({tag, ".a"}, ex_a, a);
        chk({tag, ".b"}, ex_b, b);
        chk({tag, ".ovf"}, {31'b0, ex_ovf_en}, {31'b0, ovf});
        chk({tag, ".br"}, {30'b0, ex_branch}, {30'b0, br});
        chk({tag, ".ri"}, {31'b0, ex_ri}, {31'b0, ri});
    endtask

    task automatic drive(input logic v, input logic [5:0] op,
                         input logic [5:0] fn, input logic [15:0] imm,
                         input logic [31:0] rs, input logic [31:0] rt);
        id_valid   = v;
        id_op      = op;
        id_funct   = fn;
        id_imm     = imm;
        id_rs_data = rs;
        id_rt_data = rt;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        reset_n = 1'b0;
        stall   = 1'b0;
        flush   = 1'b0;
        drive(1'b1, 6'h00, 6'h20, 16'h0, 32'h11, 32'h22);
        #1;
        expect_all("rst0", 0, 4'h0, 0, 0, 0, 2'b00, 0);
        tick();
        expect_all("rst_hold", 0, 4'h0, 0, 0, 0, 2'b00, 0);
        reset_n = 1'b1;

        drive(1'b1, 6'h00, 6'h20, 16'h0, 32'h7FFFFFFF, 32'h1);
        tick();
        expect_all("add", 1, 4'b0010, 32'h7FFFFFFF, 32'h1, 1, 2'b00, 0);

        drive(1'b1, 6'h00, 6'h21, 16'h0, 32'h7FFFFFFF, 32'h1);
        tick();
        expect_all("addu", 1, 4'b0010, 32'h7FFFFFFF, 32'h1, 0, 2'b00, 0);

        drive(1'b1, 6'h00, 6'h22, 16'h0, 32'h5, 32'h3);
        tick();
        expect_all("sub", 1, 4'b0110, 32'h5, 32'h3, 1, 2'b00, 0);

        drive(1'b1, 6'h0C, 6'h00, 16'h8000, 32'h1234, 32'h9);
        tick();
        expect_all("andi", 1, 4'b0000, 32'h1234, 32'h00008000, 0, 2'b00, 0);

        drive(1'b1, 6'h0D, 6'h00, 16'hFFFF, 32'h1234, 32'h9);
        tick();
        expect_all("ori", 1, 4'b0001, 32'h1234, 32'h0000FFFF, 0, 2'b00, 0);

        drive(1'b1, 6'h08, 6'h00, 16'h8000, 32'h1234, 32'h9);
        tick();
        expect_all("addi", 1, 4'b0010, 32'h1234, 32'hFFFF8000, 1, 2'b00, 0);

        drive(1'b1, 6'h0E, 6'h00, 16'h8001, 32'hA, 32'h9);
        tick();
        expect_all("xori", 1, 4'b1101, 32'hA, 32'h00008001, 0, 2'b00, 0);

        drive(1'b1, 6'h0A, 6'h00, 16'hFFFF, 32'hB, 32'h9);
        tick();
        expect_all("slti", 1, 4'b0111, 32'hB, 32'hFFFFFFFF, 0, 2'b00, 0);

        drive(1'b1, 6'h23, 6'h00, 16'hFFFC, 32'h100, 32'h9);
        tick();
        expect_all("lw", 1, 4'b0010, 32'h100, 32'hFFFFFFFC, 0, 2'b00, 0);

        drive(1'b1, 6'h2B, 6'h00, 16'h0010, 32'h200, 32'h9);
        tick();
        expect_all("sw", 1, 4'b0010, 32'h200, 32'h00000010, 0, 2'b00, 0);

        drive(1'b1, 6'h0F, 6'h00, 16'h1234, 32'hFFFFFFFF, 32'h9);
        tick();
        expect_all("lui", 1, 4'b0001, 32'h0, 32'h12340000, 0, 2'b00, 0);

        drive(1'b1, 6'h04, 6'h00, 16'h0040, 32'hA, 32'hB);
        tick();
        expect_all("beq", 1, 4'b0110, 32'hA, 32'hB, 0, 2'b01, 0);

        drive(1'b1, 6'h05, 6'h00, 16'h0040, 32'hC, 32'hD);
        tick();
        expect_all("bne", 1, 4'b0110, 32'hC, 32'hD, 0, 2'b10, 0);

        drive(1'b1, 6'h00, 6'h27, 16'h0, 32'hF0, 32'h0F);
        tick();
        expect_all("nor", 1, 4'b1100, 32'hF0, 32'h0F, 0, 2'b00, 0);

        drive(1'b1, 6'h00, 6'h2A, 16'h0, 32'h3, 32'h4);
        tick();
        expect_all("slt", 1, 4'b0111, 32'h3, 32'h4, 0, 2'b00, 0);

        stall = 1'b1;
        drive(1'b1, 6'h00, 6'h20, 16'h0, 32'h55, 32'h66);
        tick();
        expect_all("stall1", 1, 4'b0111, 32'h3, 32'h4, 0, 2'b00, 0);
        drive(1'b1, 6'h04, 6'h00, 16'h0, 32'h77, 32'h88);
        tick();
        expect_all("stall2", 1, 4'b0111, 32'h3, 32'h4, 0, 2'b00, 0);
        drive(1'b1, 6'h3F, 6'h00, 16'h0, 32'h99, 32'hAA);
        tick();
        expect_all("stall3", 1, 4'b0111, 32'h3, 32'h4, 0, 2'b00, 0);

        flush = 1'b1;
        drive(1'b1, 6'h00, 6'h20, 16'h0, 32'h55, 32'h66);
        tick();
        expect_all("stall_flush", 0, 4'h0, 0, 0, 0, 2'b00, 0);

        stall = 1'b0;
        flush = 1'b0;
        tick();
        expect_all("reload", 1, 4'b0010, 32'h55, 32'h66, 1, 2'b00, 0);
        flush = 1'b1;
        tick();
        expect_all("flush", 0, 4'h0, 0, 0, 0, 2'b00, 0);
        flush = 1'b0;

        drive(1'b1, 6'h3F, 6'h00, 16'h1234, 32'h55, 32'h66);
        tick();
        expect_all("ri_op", 1, 4'h0, 0, 0, 0, 2'b00, 1);

        drive(1'b1, 6'h00, 6'h3F, 16'h1234, 32'h55, 32'h66);
        tick();
        expect_all("ri_fn", 1, 4'h0, 0, 0, 0, 2'b00, 1);

        drive(1'b0, 6'h3F, 6'h00, 16'h1234, 32'h55, 32'h66);
        tick();
        expect_all("bubble", 0, 4'h0, 0, 0, 0, 2'b00, 0);

        drive(1'b1, 6'h05, 6'h00, 16'h0, 32'h1, 32'h2);
        tick();
        expect_all("pre_rst", 1, 4'b0110, 32'h1, 32'h2, 0, 2'b10, 0);
        reset_n = 1'b0;
        #1;
        expect_all("rst_async", 0, 4'h0, 0, 0, 0, 2'b00, 0);
        tick();
        expect_all("rst_low1", 0, 4'h0, 0, 0, 0, 2'b00, 0);
        stall = 1'b1;
        tick();
        expect_all("rst_low2", 0, 4'h0, 0, 0, 0, 2'b00, 0);
        stall   = 1'b0;
        reset_n = 1'b1;
        tick();
        expect_all("post_rst", 1, 4'b0110, 32'h1, 32'h2, 0, 2'b10, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
